// File: rtl/frame_capture.sv
// Camera byte-stream writer: waits for a VSYNC-framed frame, stores BYTES_PER_FRAME
// bytes at addresses 0.. and holds the frame until the reader signals it consumed it.
module frame_capture #(
  parameter int BYTES_PER_FRAME = 19200,
  parameter int ADDR_W          = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_vsync,
  input  logic              i_href,
  input  logic              i_px_valid,
  input  logic [7:0]        i_data,
  input  logic              i_frame_consumed,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [7:0]        o_ram_data,
  output logic              o_ram_we,
  output logic              o_busy,
  output logic              o_frame_ready,
  output logic              o_frame_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Counter is one bit wider than the address so a full 2^ADDR_W frame is representable.
  localparam logic [ADDR_W:0] FRAME_BYTES = BYTES_PER_FRAME[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE     = 1;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic                vsync_q;
  logic                rise;
  logic                fall;

  assign rise = i_vsync & ~vsync_q;
  assign fall = ~i_vsync & vsync_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      err_q   <= err_d;
      vsync_q <= i_vsync;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_WAIT_VSYNC;
      end
      S_WAIT_VSYNC: begin
        if (rise) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (fall) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end
      end
      S_CAPTURE: begin
        // A VSYNC rise ends the frame and wins over any byte strobed in the same cycle.
        if (rise) begin
          if (cnt_q == FRAME_BYTES) begin
            state_d = S_DONE;
          end else begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_ARMED;
          end
        end else if (i_href && i_px_valid && (cnt_q < FRAME_BYTES)) begin
          we_d   = 1'b1;
          data_d = i_data;
          addr_d = cnt_q[ADDR_W-1:0];
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        if (i_frame_consumed) state_d = i_start ? S_WAIT_VSYNC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_ram_address = addr_q;
    o_ram_data    = data_q;
    o_ram_we      = we_q;
    o_frame_error = err_q;
    o_busy        = (state_q == S_WAIT_VSYNC) || (state_q == S_ARMED) || (state_q == S_CAPTURE);
    o_frame_ready = (state_q == S_DONE);
  end

endmodule
